branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, meaning number of 2-bit predictor counters (power of 2); IDX_W = log2(BHT_ENTRIES).
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ex_valid  input  1  control-flow instruction present in EX.
REQ-006 SHALL have port ex_is_branch  input  1  instruction is conditional branch.
REQ-007 SHALL have port ex_is_jump  input  1  instruction is JAL/JALR.
REQ-008 SHALL have port ex_funct3  input  3  branch funct3.
REQ-009 SHALL have port ex_pc  input  N  PC of EX instruction.
REQ-010 SHALL have port ex_target  input  N  computed taken target.
REQ-011 SHALL have port ex_pred_taken  input  1  prediction used at fetch.
REQ-012 SHALL have port stall  input  1  EX held; no resolution this cycle.
REQ-013 SHALL have ports BrEq, BrLt  input  1 each  comparator flags.
REQ-014 SHALL have port BrUn  output  1  unsigned-compare select to comparator.
REQ-015 SHALL have port if_pc  input  N  fetch PC for prediction lookup.
REQ-016 SHALL have port if_pred_taken  output  1  prediction for if_pc.
REQ-017 SHALL have ports redirect  output  1, redirect_pc  output  N  registered PC redirect/flush request.
REQ-018 SHALL have ports clear_stats  input  1, branch_cnt  output  32, mispredict_cnt  output  32  statistics.

Function
REQ-019 BrUn SHALL be combinational: 1 iff ex_funct3 is 110 or 111.
REQ-020 Resolution SHALL occur in a cycle iff ex_valid=1, stall=0, redirect=0 (instruction behind a redirect is wrong-path and ignored).
REQ-021 Actual taken: 000 BrEq; 001 !BrEq; 100/110 BrLt; 101/111 !BrLt; 010/011 not taken, no BHT update, not counted.
REQ-022 Jump (ex_is_jump=1, priority over ex_is_branch) SHALL be taken and redirect to ex_target regardless of ex_pred_taken; no BHT update, no count.
REQ-023 Conditional mispredict = (actual taken != ex_pred_taken); redirect_pc = actual taken ? ex_target : ex_pc+4 (mod 2^N).
REQ-024 redirect/redirect_pc SHALL be registered: asserted the cycle after the resolving cycle, exactly one cycle; redirect_pc holds last value when redirect=0.
REQ-025 BHT: BHT_ENTRIES 2-bit saturating counters indexed ex_pc[IDX_W+1:2]; resolved conditional branch taken increments (saturate 3), not taken decrements (saturate 0), written at clock edge ending the resolving cycle.
REQ-026 if_pred_taken SHALL be combinational: MSB of counter at if_pc[IDX_W+1:2]; same-cycle update to same entry NOT bypassed (old value returned).
REQ-027 branch_cnt SHALL increment per resolved conditional branch with legal funct3; mispredict_cnt per conditional mispredict; both wrap at 2^32.
REQ-028 clear_stats SHALL synchronously zero both counters, priority over same-cycle increment; BHT unaffected.
REQ-029 stall=1 SHALL freeze resolution, BHT and counters; a pending registered redirect still issues.

Reset
REQ-030 rst=1 SHALL immediately force redirect=0, redirect_pc=0, branch_cnt=0, mispredict_cnt=0, all BHT counters=01 (if_pred_taken=0).
REQ-031 Reset mid-operation SHALL drop any pending redirect; first resolution possible in first cycle with rst=0.

Verification
REQ-032 BEQ, BrEq=1, pred=0, ex_pc=0x100, target=0x140 -> next cycle redirect=1, redirect_pc=0x140; branch_cnt=1, mispredict_cnt=1; entry 0 = 10.
REQ-033 BGEU funct3=111 -> BrUn=1; BrLt=1, pred=1, ex_pc=0x200 -> redirect_pc=0x204; BHT[0] decrements.
REQ-034 Four taken resolutions at ex_pc=0x40 -> counter saturates 11; if_pc=0x40 gives if_pred_taken=1; fifth taken keeps 11, no redirect when pred=1.
REQ-035 JAL with pred=1 target=0x800 -> redirect_pc=0x800; ex_valid in the redirect cycle -> ignored, no count, no BHT change.
REQ-036 funct3=010, stall=1 cases, and clear_stats coincident with mispredict -> no update/counts 0; rst asserted while redirect pending -> redirect=0 next cycle, BHT=01.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution in EX: computes actual direction, issues registered redirects,
// trains a 2-bit BHT and keeps branch/mispredict statistics.
module branch_resolve #(
    parameter int unsigned N           = 32,
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_valid,
    input  logic         ex_is_branch,
    input  logic         ex_is_jump,
    input  logic [2:0]   ex_funct3,
    input  logic [N-1:0] ex_pc,
    input  logic [N-1:0] ex_target,
    input  logic         ex_pred_taken,
    input  logic         stall,
    input  logic         BrEq,
    input  logic         BrLt,
    output logic         BrUn,
    input  logic [N-1:0] if_pc,
    output logic         if_pred_taken,
    output logic         redirect,
    output logic [N-1:0] redirect_pc,
    input  logic         clear_stats,
    output logic [31:0]  branch_cnt,
    output logic [31:0]  mispredict_cnt
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic             redirect_q, redirect_d;
    logic [N-1:0]     redirect_pc_q, redirect_pc_d;
    logic [31:0]      branch_cnt_q, branch_cnt_d;
    logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

    logic             resolve, jump_resolve, br_resolve, mispredict;
    logic             f3_legal, actual_taken;
    logic [IDX_W-1:0] ex_idx, if_idx;
    logic [1:0]       bht_cur, bht_nxt;
    logic             unused_if_pc;

    assign BrUn    = (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    assign ex_idx  = ex_pc[IDX_W+1:2];
    assign if_idx  = if_pc[IDX_W+1:2];
    assign unused_if_pc = ^{if_pc[N-1:IDX_W+2], if_pc[1:0]};

    // Prediction reads the stored counter; a same-cycle update is not forwarded.
    assign if_pred_taken = bht_q[if_idx][1];

    // Actual direction from comparator flags; 010/011 are not real branches.
    always_comb begin
        f3_legal     = 1'b1;
        actual_taken = 1'b0;
        case (ex_funct3)
            3'b000:         actual_taken = BrEq;
            3'b001:         actual_taken = !BrEq;
            3'b100, 3'b110: actual_taken = BrLt;
            3'b101, 3'b111: actual_taken = !BrLt;
            default:        f3_legal     = 1'b0;
        endcase
    end

    // Anything in EX while a redirect is out is wrong-path and must be dropped.
    assign resolve      = ex_valid && !stall && !redirect_q;
    assign jump_resolve = resolve && ex_is_jump;
    assign br_resolve   = resolve && !ex_is_jump && ex_is_branch && f3_legal;
    assign mispredict   = br_resolve && (actual_taken != ex_pred_taken);

    always_comb begin
        bht_cur = bht_q[ex_idx];
        bht_nxt = bht_cur;
        if (actual_taken) begin
            if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'b01;
        end
    end

    always_comb begin
        redirect_d       = jump_resolve || mispredict;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (jump_resolve) begin
            redirect_pc_d = ex_target;
        end else if (mispredict) begin
            redirect_pc_d = actual_taken ? ex_target : ex_pc + N'(4);
        end
        if (clear_stats) begin
            branch_cnt_d     = 32'd0;
            mispredict_cnt_d = 32'd0;
        end else begin
            if (br_resolve) branch_cnt_d     = branch_cnt_q + 32'd1;
            if (mispredict) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[IDX_W'(i)] <= 2'b01;
            end
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            redirect_q       <= redirect_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            if (br_resolve) bht_q[ex_idx] <= bht_nxt;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a mnemonic-level reference model predicts
// redirects, counters and predictions; a negedge monitor checks redirects.
module tb_branch_resolve;
    localparam int N   = 32;
    localparam int ENT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken, stall;
    logic [2:0]    ex_funct3;
    logic [N-1:0]  ex_pc, ex_target, if_pc, redirect_pc;
    logic          BrEq, BrLt, BrUn, if_pred_taken, redirect, clear_stats;
    logic [31:0]   branch_cnt, mispredict_cnt;

    branch_resolve #(.N(N), .BHT_ENTRIES(ENT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .stall(stall),
        .BrEq(BrEq), .BrLt(BrLt), .BrUn(BrUn), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .redirect(redirect), .redirect_pc(redirect_pc),
        .clear_stats(clear_stats), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          m_bht[ENT];
    int unsigned m_bcnt, m_mcnt;
    bit          m_red;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: redirect must appear exactly in the cycle the scoreboard says.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                n_chk++;
                if (redirect !== 1'b1 || redirect_pc !== exp_q[0].pc) begin
                    n_fail++;
                    $display("FAIL redirect: got redirect=%0b pc=0x%0h expected pc=0x%0h (cycle %0d)",
                             redirect, redirect_pc, exp_q[0].pc, cyc);
                end
                void'(exp_q.pop_front());
            end else if (redirect !== 1'b0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_redirect: got redirect=%0b pc=0x%0h expected redirect=0 (cycle %0d)",
                         redirect, redirect_pc, cyc);
            end
        end
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(ENT));
    endfunction

    // One cycle of stimulus; a,b are the register operands behind the comparator flags.
    task automatic drive(input bit v, input bit br, input bit j, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                         input bit st, input logic [7:0] a, input logic [7:0] b,
                         input bit clr, input logic [31:0] ipc);
        bit uns, taken, legal, res, nr, bi, mi;
        logic [31:0] npc;
        int idx;
        uns = (f3 == 3'd6) || (f3 == 3'd7);
        ex_valid = v; ex_is_branch = br; ex_is_jump = j; ex_funct3 = f3;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; stall = st;
        BrEq = (a == b);
        BrLt = uns ? (a < b) : ($signed(a) < $signed(b));
        clear_stats = clr; if_pc = ipc;
        #2;
        chk("BrUn", 32'(BrUn), 32'(uns));
        chk("if_pred_taken", 32'(if_pred_taken), 32'(m_bht[idx_of(ipc)] >= 2));
        case (f3)
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = $signed(a) < $signed(b);
            3'd5:    taken = $signed(a) >= $signed(b);
            3'd6:    taken = a < b;
            3'd7:    taken = a >= b;
            default: taken = 1'b0;
        endcase
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        res = v && !st && !m_red;
        nr = 0; bi = 0; mi = 0; npc = '0;
        if (res && j) begin
            nr = 1; npc = tgt;
        end else if (res && br && legal) begin
            bi = 1;
            idx = idx_of(pc);
            if (taken != pred) begin
                mi = 1; nr = 1; npc = taken ? tgt : pc + 32'd4;
            end
            m_bht[idx] = taken ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                               : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
        end
        if (nr) exp_q.push_back('{due: cyc + 1, pc: npc});
        @(posedge clk); #1;
        m_red = nr;
        if (clr) begin
            m_bcnt = 0; m_mcnt = 0;
        end else begin
            m_bcnt += 32'(bi); m_mcnt += 32'(mi);
        end
        chk("branch_cnt", branch_cnt, m_bcnt);
        chk("mispredict_cnt", mispredict_cnt, m_mcnt);
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 8'd0, 8'd0, 0, ipc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_red = 0; m_bcnt = 0; m_mcnt = 0;
        foreach (m_bht[i]) m_bht[i] = 1;
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispredict_cnt", mispredict_cnt, 32'd0);
        chk("rst_if_pred_taken", 32'(if_pred_taken), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_funct3 = '0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 0; stall = 0;
        BrEq = 0; BrLt = 0; clear_stats = 0; if_pc = '0;
        @(posedge clk); #1;
        do_reset();

        // BEQ taken, predicted not taken
        drive(1, 1, 0, 3'd0, 32'h100, 32'h140, 0, 0, 8'd5, 8'd5, 0, 32'h100);
        idle(32'h100);
        // BGEU not taken (unsigned less), predicted taken -> fall-through
        drive(1, 1, 0, 3'd7, 32'h200, 32'h280, 1, 0, 8'd1, 8'd2, 0, 32'h0);
        idle(32'h200);
        // Saturation at one entry
        for (int k = 0; k < 5; k++) drive(1, 1, 0, 3'd0, 32'h40, 32'h80, 1, 0, 8'd7, 8'd7, 0, 32'h40);
        // JAL, then wrong-path branch in the redirect cycle
        drive(1, 0, 1, 3'd0, 32'h500, 32'h800, 1, 0, 8'd0, 8'd0, 0, 32'h0);
        drive(1, 1, 0, 3'd0, 32'h44, 32'h90, 0, 0, 8'd1, 8'd1, 0, 32'h44);
        idle(32'h44);
        // Illegal funct3, stall, clear coincident with mispredict, stall under pending redirect
        drive(1, 1, 0, 3'd2, 32'h48, 32'h90, 0, 0, 8'd3, 8'd3, 0, 32'h48);
        drive(1, 1, 0, 3'd0, 32'h48, 32'h90, 0, 1, 8'd3, 8'd3, 0, 32'h48);
        drive(1, 1, 0, 3'd1, 32'h48, 32'h90, 0, 0, 8'd3, 8'd4, 1, 32'h48);
        drive(1, 1, 0, 3'd1, 32'h48, 32'h90, 0, 1, 8'd3, 8'd4, 0, 32'h48);
        idle(32'h48);
        // Reset with a redirect pending
        drive(1, 1, 0, 3'd0, 32'h4c, 32'hc0, 0, 0, 8'd9, 8'd9, 0, 32'h0);
        do_reset();
        idle(32'h40);

        for (int k = 0; k < 600; k++) begin
            logic [7:0]  a, b;
            logic [31:0] pc;
            bit st;
            if ($urandom_range(0, 149) == 0) do_reset();
            a  = 8'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
            pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 31)) << 2);
            st = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                  3'($urandom_range(0, 7)), pc, 32'($urandom) & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) == 1, st, a, b,
                  !st && ($urandom_range(0, 31) == 0), 32'($urandom_range(0, 31)) << 2);
        end

        idle(32'h0);
        idle(32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
